// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
// The lz_mask_of helper is only referenced when SEG_LZ_BLANK_EN is defined.
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   // Bit i set means digit i is a leading zero; digit 0 is never suppressed.
   function automatic logic [7:0] lz_mask_of(input logic [31:0] val);
      logic [7:0] mask;
      logic       allZero;
      mask    = '0;
      allZero = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         allZero = allZero && (val[4*i +: 4] == 4'h0);
         mask[i] = allZero;
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Digit-slot timebase: counts PRESCALE clocks per slot and flags the last one.
module seg_prescaler
   import seg_pkg::*;
#(
   parameter int unsigned PRESCALE = 6250,
   parameter int unsigned CNT_W    = $clog2(PRESCALE)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [CNT_W-1:0] slot_cnt_o,
   output logic             slot_end_o
);

   logic [CNT_W-1:0] slot_cnt_q;
   logic [CNT_W-1:0] slot_cnt_d;

   assign slot_end_o = (slot_cnt_q == CNT_W'(PRESCALE - 1));
   assign slot_cnt_d = slot_end_o ? '0 : slot_cnt_q + CNT_W'(1);
   assign slot_cnt_o = slot_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_cnt_q <= '0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit active-low seven-segment scanner with frame-boundary snapshotting.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned PRESCALE  = 6250,
   parameter int unsigned BLANK_CYC = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] debug_val_i,
   input  logic [31:0] disp_val_i,
   input  logic        sel_debug_i,
   input  logic        freeze_i,
   output logic [7:0]  an_o,
   output logic [6:0]  sev_out_o,
   output logic        frame_done_o
);

   localparam int unsigned CNT_W = $clog2(PRESCALE);

   logic [CNT_W-1:0] slot_cnt;
   logic             slot_end;

   scan_state_t      state_q, state_d;
   logic [2:0]       dig_idx_q, dig_idx_d;
   logic [31:0]      snap_q, snap_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       sev_q, sev_d;
   logic             frame_done_q;
   logic             boundary;
   logic             snapLoad;
   logic             lit;

   seg_prescaler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .slot_cnt_o (slot_cnt),
      .slot_end_o (slot_end)
   );

   assign boundary = slot_end && (dig_idx_q == 3'd7);
   assign snapLoad = boundary && !freeze_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK:   if (slot_cnt == CNT_W'(BLANK_CYC - 1)) state_d = SHOW;
         default: if (slot_end) state_d = BLANK;
      endcase
   end

`ifdef SEG_LZ_BLANK_EN
   logic [7:0] lz_mask_q, lz_mask_d;

   assign lz_mask_d = snapLoad ? lz_mask_of(snap_d) : lz_mask_q;

   // Reset value matches the cleared snapshot: only digit 0 lights.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lz_mask_q <= 8'hFE;
      end else begin
         lz_mask_q <= lz_mask_d;
      end
   end
`endif

   always_comb begin
      dig_idx_d = slot_end ? dig_idx_q + 3'd1 : dig_idx_q;
      snap_d    = snap_q;
      if (snapLoad) begin
         snap_d = sel_debug_i ? debug_val_i : disp_val_i;
      end
      lit = (state_q == SHOW);
`ifdef SEG_LZ_BLANK_EN
      lit = lit && !lz_mask_q[dig_idx_q];
`endif
      an_d  = lit ? ~(8'd1 << dig_idx_q) : AN_OFF;
      sev_d = seg_decode(snap_q[{dig_idx_q, 2'b00} +: 4]);
   end

   // Outputs lag the state/index by one cycle so they come straight from flops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= BLANK;
         dig_idx_q    <= '0;
         snap_q       <= '0;
         an_q         <= AN_OFF;
         sev_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dig_idx_q    <= dig_idx_d;
         snap_q       <= snap_d;
         an_q         <= an_d;
         sev_q        <= sev_d;
         frame_done_q <= boundary;
      end
   end

   assign an_o         = an_q;
   assign sev_out_o    = sev_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle blank.
// Expected digits are queued per frame and popped as each digit lights up.
module tb_seg_scan_ctrl;

   localparam int PRESCALE  = 8;
   localparam int BLANK_CYC = 2;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] sev;
   } digit_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] debug_val_i;
   logic [31:0] disp_val_i;
   logic        sel_debug_i;
   logic        freeze_i;
   logic [7:0]  an_o;
   logic [6:0]  sev_out_o;
   logic        frame_done_o;

   digit_t      expQ[$];
   digit_t      expD;
   int          checks = 0;
   int          errors = 0;
   int          cycle  = 0;
   bit          monEn  = 1'b0;
   bit          blankCheckEn;
   logic [7:0]  prevAn = 8'hFF;
   int          blankRun = 0;

   seg_scan_ctrl #(
      .PRESCALE  (PRESCALE),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .debug_val_i  (debug_val_i),
      .disp_val_i   (disp_val_i),
      .sel_debug_i  (sel_debug_i),
      .freeze_i     (freeze_i),
      .an_o         (an_o),
      .sev_out_o    (sev_out_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycle++;

   function automatic logic [6:0] refSeg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic bit lzHidden(input logic [31:0] v, input int i);
`ifdef SEG_LZ_BLANK_EN
      if (i == 0) return 1'b0;
      return ((v >> (4 * i)) == 32'h0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic pushFrame(input logic [31:0] v);
      digit_t d;
      for (int i = 0; i < 8; i++) begin
         if (!lzHidden(v, i)) begin
            d.an  = ~(8'd1 << i);
            d.sev = refSeg(v[4*i +: 4]);
            expQ.push_back(d);
         end
      end
   endtask

   // Each time a new anode lights up, compare it against the next queued digit.
   always @(negedge clk_i) begin
      if (rst_i) begin
         prevAn   = 8'hFF;
         blankRun = 0;
      end else begin
         if (an_o === 8'hFF) begin
            blankRun++;
         end else if (an_o !== prevAn) begin
            if (monEn) begin
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL digit_unexpected: an=%h sev=%b, required no lit digit", an_o, sev_out_o);
               end else begin
                  expD = expQ.pop_front();
                  if ({an_o, sev_out_o} !== expD) begin
                     errors++;
                     $display("[TB] FAIL digit_value: an=%h sev=%b, required an=%h sev=%b",
                              an_o, sev_out_o, expD.an, expD.sev);
                  end
               end
               if (blankCheckEn) begin
                  checks++;
                  if (blankRun != BLANK_CYC) begin
                     errors++;
                     $display("[TB] FAIL blank_len: %0d cycles before an=%h, required %0d",
                              blankRun, an_o, BLANK_CYC);
                  end
               end
            end
            blankRun = 0;
         end
         prevAn = an_o;
      end
   end

   task automatic waitFD(input int budget, input string tag);
      int n;
      n = 0;
      @(negedge clk_i);
      while (frame_done_o !== 1'b1 && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (frame_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_timeout: frame_done=%b after %0d cycles, required 1", tag, frame_done_o, n);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_drain: %0d digits still pending at frame end, required 0", tag, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic waitAn(input logic [7:0] target, input string tag);
      int n;
      n = 0;
      while (an_o !== target && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (an_o !== target) begin
         errors++;
         $display("[TB] FAIL %s_wait_an: an=%h, required %h", tag, an_o, target);
      end
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      sel_debug_i = 1'b1;
      debug_val_i = 32'h1234_5678;
      disp_val_i  = 32'h0;
      freeze_i    = 1'b0;
      repeat (3) @(negedge clk_i);
      checks += 3;
      if (an_o !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL reset_an: got %h, required FF", an_o);
      end
      if (sev_out_o !== 7'h7F) begin
         errors++;
         $display("[TB] FAIL reset_sev: got %h, required 7F", sev_out_o);
      end
      if (frame_done_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_fd: got %b, required 0", frame_done_o);
      end
      expQ.delete();
      monEn = 1'b1;
      pushFrame(32'h0);
      #2 rst_i = 1'b0;
      waitFD(80, "frame1");
      pushFrame(32'h1234_5678);
      waitFD(80, "frame2");
   endtask

   task automatic test_anode_seq();
      int t0;
      pushFrame(32'h1234_5678);
      waitFD(80, "seq_a");
      t0 = cycle;
      pushFrame(32'h1234_5678);
      @(negedge clk_i);
      checks++;
      if (frame_done_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fd_width: frame_done=%b one cycle after pulse, required 0", frame_done_o);
      end
      waitFD(80, "seq_b");
      checks++;
      if (cycle - t0 != 8 * PRESCALE) begin
         errors++;
         $display("[TB] FAIL fd_period: %0d cycles, required %0d", cycle - t0, 8 * PRESCALE);
      end
   endtask

   task automatic test_mid_frame_switch();
      pushFrame(32'h1234_5678);
      waitAn(8'hF7, "switch");
      sel_debug_i = 1'b0;
      disp_val_i  = 32'hCAFE_F00D;
      debug_val_i = 32'hDEAD_BEEF;
      waitFD(80, "switch_old");
      pushFrame(32'hCAFE_F00D);
      waitFD(80, "switch_new");
   endtask

   task automatic test_freeze();
      pushFrame(32'hCAFE_F00D);
      sel_debug_i = 1'b1;
      freeze_i    = 1'b1;
      debug_val_i = 32'h1111_1111;
      waitFD(80, "freeze_a");
      pushFrame(32'hCAFE_F00D);
      debug_val_i = 32'h9B65_4321;
      waitFD(80, "freeze_b");
      pushFrame(32'hCAFE_F00D);
      freeze_i = 1'b0;
      waitFD(80, "freeze_c");
      pushFrame(32'h9B65_4321);
      waitFD(80, "freeze_d");
      // Raise freeze exactly in the boundary cycle: that load must be blocked.
      pushFrame(32'h9B65_4321);
      debug_val_i = 32'hA5A5_A5A5;
      repeat (8 * PRESCALE - 1) @(negedge clk_i);
      freeze_i = 1'b1;
      waitFD(8, "freeze_edge");
      pushFrame(32'h9B65_4321);
      freeze_i    = 1'b0;
      debug_val_i = 32'h9B65_4321;
      waitFD(80, "freeze_hold");
   endtask

   task automatic test_reset_mid();
      pushFrame(32'h9B65_4321);
      waitAn(8'hDF, "rstmid");
      #2 rst_i = 1'b1;
      #1;
      checks += 3;
      if (an_o !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL async_an: got %h, required FF", an_o);
      end
      if (sev_out_o !== 7'h7F) begin
         errors++;
         $display("[TB] FAIL async_sev: got %h, required 7F", sev_out_o);
      end
      if (frame_done_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_fd: got %b, required 0", frame_done_o);
      end
      expQ.delete();
      repeat (2) @(negedge clk_i);
      pushFrame(32'h0);
      #2 rst_i = 1'b0;
      waitFD(80, "rstmid_zero");
      pushFrame(32'h9B65_4321);
      waitFD(80, "rstmid_load");
   endtask

   task automatic test_lz_blank();
      int n;
      int otherLit;
      pushFrame(32'h9B65_4321);
      debug_val_i = 32'h0000_00A5;
      waitFD(80, "lz_pre");
      pushFrame(32'h0000_00A5);
      n        = 0;
      otherLit = 0;
      do begin
         @(negedge clk_i);
         n++;
         if (an_o !== 8'hFF && an_o !== 8'hFE && an_o !== 8'hFD) otherLit++;
      end while (frame_done_o !== 1'b1 && n < 80);
      checks++;
      if (frame_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lz_timeout: frame_done=%b after %0d cycles, required 1", frame_done_o, n);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL lz_drain: %0d digits pending, required 0", expQ.size());
      end
      checks++;
`ifdef SEG_LZ_BLANK_EN
      if (otherLit != 0) begin
         errors++;
         $display("[TB] FAIL lz_other_digits: %0d cycles with digits 2-7 lit, required 0", otherLit);
      end
`else
      if (otherLit != 6 * (PRESCALE - BLANK_CYC)) begin
         errors++;
         $display("[TB] FAIL lz_other_digits: %0d cycles with digits 2-7 lit, required %0d",
                  otherLit, 6 * (PRESCALE - BLANK_CYC));
      end
`endif
      monEn = 1'b0;
   endtask

   initial begin
`ifdef SEG_LZ_BLANK_EN
      blankCheckEn = 1'b0;
`else
      blankCheckEn = 1'b1;
`endif
      test_reset();
      test_anode_seq();
      test_mid_frame_switch();
      test_freeze();
      test_reset_mid();
      test_lz_blank();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit, active-low seven-segment display on the board top.
- Selects between the core debug word and the MMIO display word, and snapshots the chosen word at frame boundaries so digits never tear.
- Steps the anodes from a programmable prescaler and drives registered anode and segment outputs.
- Replaces the free-running anode rotation on the 5 MHz clock; runs on the 50 MHz core clock.

Parameters:
- PRESCALE, 6250, clk cycles per digit slot (50 MHz / 6250 = 8 kHz digit rate, 1 kHz frame rate); legal range 4 to 2^20.
- BLANK_CYC, 64, cycles at the start of each slot with all anodes off (anti-ghosting); must be less than PRESCALE.

Ports:
- clk  in  1  core clock (50 MHz domain).
- Rst  in  1  reset; asynchronous, active-high.
- debug_val  in  32  core debug word.
- disp_val  in  32  MMIO display word.
- sel_debug  in  1  1 = show debug_val, 0 = show disp_val; sampled only at a frame boundary.
- freeze  in  1  1 = keep the current snapshot across frame boundaries.
- an  out  8  anodes, active-low, one-hot-zero.
- sev_out  out  7  segments {a,b,c,d,e,f,g}, active-low.
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - slot_cnt = 0, dig_idx = 0, snap = 32'h0.
  - an = 8'hFF, sev_out = 7'h7F, frame_done = 0.
  - The state machine enters BLANK.
- slot_cnt:
  - Counts 0 to PRESCALE-1 and wraps to 0.
  - slot_end is asserted when slot_cnt == PRESCALE-1.
- dig_idx:
  - 3 bits, increments on slot_end, wraps from 7 to 0.
  - The frame boundary is the slot_end with dig_idx == 7.
- At each frame boundary:
  - frame_done = 1 in the following cycle only.
  - If freeze = 0: snap is loaded with sel_debug ? debug_val : disp_val, sampled in the boundary cycle.
  - If freeze = 1: snap is held.
- State machine:
  - BLANK: active for slot_cnt < BLANK_CYC. an = 8'hFF. Moves to SHOW when slot_cnt == BLANK_CYC-1.
  - SHOW: an[dig_idx] = 0, all other anode bits = 1. sev_out = decode(snap[4*dig_idx +: 4]). Moves to BLANK on slot_end.
- Output timing:
  - an and sev_out are registered, with 1 cycle of latency from the state and index change.
  - an = 8'hFF exactly during BLANK (offset by that 1 cycle).
  - sev_out may change during BLANK; it is don't-care while all anodes are off.
- Decode is active-low, standard codebase table:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Digit mapping: dig_idx 0 is the rightmost digit and shows snap[3:0]; dig_idx 7 shows snap[31:28].
- sel_debug or debug_val changing mid-frame has no visible effect until the next boundary.
- freeze rising in the same cycle as a boundary blocks that load.
- Reset mid-frame forces all outputs to their reset values immediately (asynchronous). The first frame after reset displays 0 until the first boundary loads snap.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - At the boundary, compute lz_mask from the new snapshot value.
  - Digit i is suppressed when all nibbles i..7 are zero and i != 0; digit 0 is always shown.
  - A suppressed digit keeps an = 8'hFF for its whole slot.
  - Example: snap = 32'h0000_00A5 lights digits 0 and 1 only.
- Undefined: all 8 digits are shown. No lz_mask logic is synthesized.

Decomposition:
- Package seg_pkg holds:
  - typedef scan_state_t {BLANK, SHOW}.
  - constant SEG_OFF = 7'h7F.
  - constant AN_OFF = 8'hFF.
  - function seg_decode(logic [3:0]) returning logic [6:0].
- One sub-module, seg_prescaler (parameter PRESCALE): outputs slot_cnt and slot_end.
- Everything else lives in seg_scan_ctrl.

Test Plan (all scenarios use PRESCALE = 8, BLANK_CYC = 2):
- Reset release with sel_debug = 1 and debug_val = 32'h1234_5678:
  - During frame 1: an = FE once SHOW begins; sev_out = 0000001.
  - After the first frame_done: in SHOW, digit 0 gives sev_out = 0000000 ("8") and digit 7 gives sev_out = 1001111 ("1").
- Anode sequencing:
  - an steps FE, FD, FB, F7, EF, DF, BF, 7F in SHOW.
  - an = FF for exactly 2 cycles at the start of each 8-cycle slot.
  - frame_done pulses every 64 cycles.
- Mid-frame source change:
  - Toggle sel_debug to 0 with disp_val = 32'hCAFE_F00D at digit 3.
  - The remaining digits still show the old word; the next frame shows D on digit 0 (sev_out = 1000010).
- freeze = 1 across two boundaries while debug_val changes:
  - snap is unchanged.
  - After freeze is released, the new value appears one frame later.
- Assert Rst during the SHOW slot of digit 5:
  - an = FF and sev_out = 7F in the same cycle, without waiting for a clock edge.
  - After release, scanning restarts at digit 0.
- With SEG_LZ_BLANK_EN defined and snap = 32'h0000_00A5:
  - Only FE and FD are ever driven.
  - Digits 2–7 stay FF for their whole slots.
